// File: rtl/ifu.sv
// Instruction fetch unit: holds the pc, issues one imem read at a time and
// presents the returned word with its pc to decode; execute redirects kill in-flight work.
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] ST_REQ   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   logic [1:0]  state_r,       state_s;
   logic [31:0] pc_r,          pc_s;
   logic [31:0] inst_r,        inst_s;
   logic [31:0] inst_pc_r,     inst_pc_s;
   logic [31:0] fetch_count_r, fetch_count_s;

   logic [31:0] redir_pc_s;
   logic        dec_hs_s;
   logic        unused_redirect_bits_s;

   // Redirect targets are word aligned; the low bits are dropped, not trapped.
   assign redir_pc_s             = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_bits_s = ^redirect_pc[1:0];

   assign imem_req_valid = (state_r == ST_REQ)  & ~redirect_valid & ~rst;
   assign inst_valid     = (state_r == ST_HOLD) & ~redirect_valid & ~rst;
   assign imem_req_addr  = pc_r;
   assign inst           = inst_r;
   assign inst_pc        = inst_pc_r;
   assign fetch_count    = fetch_count_r;
   assign dec_hs_s       = inst_valid & inst_ready;

   // Next-state logic for the fetch FSM and its datapath registers.
   always_comb begin
      state_s       = state_r;
      pc_s          = pc_r;
      inst_s        = inst_r;
      inst_pc_s     = inst_pc_r;
      fetch_count_s = fetch_count_r;
      case (state_r)
         ST_REQ: begin
            if (redirect_valid) begin
               pc_s = redir_pc_s;
            end else if (imem_req_ready) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid && redirect_valid) begin
               pc_s    = redir_pc_s;
               state_s = ST_REQ;
            end else if (imem_rsp_valid) begin
               inst_s    = imem_rsp_data;
               inst_pc_s = pc_r;
               pc_s      = pc_r + 32'd4;
               state_s   = ST_HOLD;
            end else if (redirect_valid) begin
               pc_s    = redir_pc_s;
               state_s = ST_FLUSH;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_FLUSH: begin
            // The stale response still has to be drained before a new request.
            if (redirect_valid) begin
               pc_s = redir_pc_s;
            end else begin
               pc_s = pc_r;
            end
            if (imem_rsp_valid) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_FLUSH;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               pc_s    = redir_pc_s;
               state_s = ST_REQ;
            end else if (dec_hs_s) begin
               fetch_count_s = fetch_count_r + 32'd1;
               state_s       = ST_REQ;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_REQ;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_REQ;
         pc_r          <= RESET_PC;
         inst_r        <= 32'd0;
         inst_pc_r     <= 32'd0;
         fetch_count_r <= 32'd0;
      end else begin
         state_r       <= state_s;
         pc_r          <= pc_s;
         inst_r        <= inst_s;
         inst_pc_r     <= inst_pc_s;
         fetch_count_r <= fetch_count_s;
      end
   end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a small imem model with programmable response delay
// and hand-computed expectations for fetch, backpressure, redirects and reset.
module tb_ifu;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] fetch_count;

   int n_chk  = 0;
   int n_pass = 0;

   // Memory model state.
   int          rsp_delay = 1;
   bit          pend      = 1'b0;
   int          pend_cnt  = 0;
   logic [31:0] pend_addr = 32'd0;
   int          n_issue   = 0;
   int          n_dec     = 0;

   localparam logic [31:0] KEY = 32'hDEAD_BEEF;

   ifu #(.RESET_PC(32'h8000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: sample handshakes before the edge, then advance the memory model.
   task automatic tick();
      logic        hs;
      logic [31:0] a;
      #1;
      hs = imem_req_valid & imem_req_ready;
      a  = imem_req_addr;
      if (inst_valid & inst_ready) n_dec++;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rst) pend = 1'b0;
      if (hs) begin
         n_issue++;
         pend      = 1'b1;
         pend_cnt  = rsp_delay;
         pend_addr = a;
      end
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_addr ^ KEY;
            pend           = 1'b0;
         end
      end
   endtask

   initial begin
      logic [31:0] a;
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;

      tick();
      tick();
      chk("rst_req_valid",  {31'd0, imem_req_valid}, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid},     32'd0);
      chk("rst_inst",       inst,        32'd0);
      chk("rst_inst_pc",    inst_pc,     32'd0);
      chk("rst_fcount",     fetch_count, 32'd0);

      // Streaming fetch at one instruction per three cycles.
      rst            = 1'b0;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a = 32'h8000_0000 + 32'(4 * k);
         #1;
         chk("str_req_valid", {31'd0, imem_req_valid}, 32'd1);
         chk("str_req_addr",  imem_req_addr, a);
         tick();
         chk("str_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
         tick();
         chk("str_inst_valid", {31'd0, inst_valid}, 32'd1);
         chk("str_inst",       inst,    a ^ KEY);
         chk("str_inst_pc",    inst_pc, a);
         tick();
      end
      chk("str_fcount", fetch_count, 32'd3);

      // Request backpressure, then decode backpressure.
      imem_req_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
         chk("bp_req_addr",  imem_req_addr, 32'h8000_000C);
         tick();
      end
      chk("bp_no_issue", 32'(n_issue), 32'd3);
      imem_req_ready = 1'b1;
      inst_ready     = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
         chk("bp_inst",       inst, 32'h8000_000C ^ KEY);
         chk("bp_fcount",     fetch_count, 32'd3);
         tick();
      end
      chk("bp_single_issue", 32'(n_issue), 32'd4);
      inst_ready = 1'b1;
      tick();
      chk("bp_fcount_after", fetch_count, 32'd4);
      chk("bp_next_addr",    imem_req_addr, 32'h8000_0010);

      // Redirect in WAIT; the stale response arrives three cycles after acceptance.
      rsp_delay = 3;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0103;
      tick();
      redirect_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("fl_req_valid",  {31'd0, imem_req_valid}, 32'd0);
         chk("fl_inst_valid", {31'd0, inst_valid},     32'd0);
         tick();
      end
      #1;
      chk("fl_req_valid_after", {31'd0, imem_req_valid}, 32'd1);
      chk("fl_req_addr",  imem_req_addr, 32'h8000_0100);
      chk("fl_stale_inst", inst, 32'h8000_000C ^ KEY);
      chk("fl_no_decode", 32'(n_dec), 32'd4);

      // Redirect while holding, with decode ready in the same cycle.
      rsp_delay = 1;
      tick();
      tick();
      chk("hr_inst_pc", inst_pc, 32'h8000_0100);
      chk("hr_inst",    inst,    32'h8000_0100 ^ KEY);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      #1;
      chk("hr_inst_valid", {31'd0, inst_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("hr_fcount",    fetch_count, 32'd4);
      chk("hr_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("hr_req_addr",  imem_req_addr, 32'h8000_0200);

      // Redirect to the top word; pc+4 wraps to zero.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      #1;
      chk("wr_req_blocked", {31'd0, imem_req_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("wr_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      tick();
      tick();
      chk("wr_inst_pc", inst_pc, 32'hFFFF_FFFC);
      chk("wr_inst",    inst,    32'h2152_4113);
      tick();
      chk("wr_fcount",    fetch_count,   32'd5);
      chk("wr_next_addr", imem_req_addr, 32'h0000_0000);

      // Reset while flushing.
      rsp_delay = 3;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0300;
      tick();
      redirect_valid = 1'b0;
      rst            = 1'b1;
      #1;
      chk("rf_req_valid",  {31'd0, imem_req_valid}, 32'd0);
      chk("rf_inst_valid", {31'd0, inst_valid},     32'd0);
      tick();
      chk("rf_inst",    inst,        32'd0);
      chk("rf_inst_pc", inst_pc,     32'd0);
      chk("rf_fcount",  fetch_count, 32'd0);
      rst = 1'b0;
      #1;
      chk("rf_req_valid_after", {31'd0, imem_req_valid}, 32'd1);
      chk("rf_req_addr", imem_req_addr, 32'h8000_0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
